// File: rtl/wb_pkg.sv
// Shared types for the write-back queue: load-type encoding and the queue entry.
// Per-entry pc/instr/is_load fields exist only when WB_TRACER_EN is defined.
package wb_pkg;

  // Entry result width; write_back_queue XLEN must match it.
  localparam int unsigned WB_XLEN = 32;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } ld_type_e;

  typedef struct packed {
    logic [4:0]         rd;
    logic               we;
    logic [WB_XLEN-1:0] result;
`ifdef WB_TRACER_EN
    logic [WB_XLEN-1:0] pc;
    logic [31:0]        instr;
    logic               is_load;
`endif
  } wb_entry_t;

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: picks the byte/halfword lane addressed by the
// byte offset, then sign- or zero-extends it according to the funct3 load type.
module load_align
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      ld_type,
  input  logic [1:0]      offset,
  input  logic [31:0]     word,
  output logic [XLEN-1:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = '0;
    case (offset)
      2'd0: lane_b = word[7:0];
      2'd1: lane_b = word[15:8];
      2'd2: lane_b = word[23:16];
      2'd3: lane_b = word[31:24];
      default: lane_b = '0;
    endcase
    lane_h = offset[1] ? word[31:16] : word[15:0];

    // Undefined encodings (011, 110, 111) fall through to a full-word load.
    case (ld_type_e'(ld_type))
      LB:      result = XLEN'($signed(lane_b));
      LBU:     result = XLEN'(lane_b);
      LH:      result = XLEN'($signed(lane_h));
      LHU:     result = XLEN'(lane_h);
      default: result = XLEN'($signed(word));
    endcase
  end

endmodule

// File: rtl/write_back_queue.sv
// In-order write-back queue between execute/load and the register file.
// Define WB_TRACER_EN to add per-entry pc/instr storage and the trc_* retire trace.
module write_back_queue
  import wb_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [XLEN-1:0]          ex_result_i,
  input  logic [XLEN-1:0]          load_data_i,
  input  logic [4:0]               rd_addr_i,
  input  logic                     rd_we_i,
  input  logic                     is_load_i,
  input  logic [2:0]               ld_type_i,
  output logic                     rf_we_o,
  output logic [4:0]               rf_addr_o,
  output logic [XLEN-1:0]          rf_data_o,
  input  logic                     rf_gnt_i,
  output logic [$clog2(DEPTH):0]   count_o
`ifdef WB_TRACER_EN
  ,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [31:0]              instr_i,
  output logic                     trc_valid_o,
  output logic [XLEN-1:0]          trc_pc_o,
  output logic [31:0]              trc_instr_o,
  output logic [4:0]               trc_reg_addr_o,
  output logic [XLEN-1:0]          trc_reg_data_o,
  output logic                     trc_is_load_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   count;
  wb_entry_t       q [DEPTH];
  wb_entry_t       head;
  wb_entry_t       push_entry;
  logic            head_valid;
  logic            head_we;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] ld_result;

  load_align #(.XLEN(XLEN)) u_load_align (
    .ld_type (ld_type_i),
    .offset  (ex_result_i[1:0]),
    .word    (load_data_i[31:0]),
    .result  (ld_result)
  );

  always_comb begin
    push_entry        = '0;
    push_entry.rd     = rd_addr_i;
    push_entry.we     = rd_we_i;
    push_entry.result = is_load_i ? ld_result : ex_result_i;
`ifdef WB_TRACER_EN
    push_entry.pc      = pc_i;
    push_entry.instr   = instr_i;
    push_entry.is_load = is_load_i;
`endif
  end

  // Empty queue drives zeros so stale storage never shows on rf_addr_o/rf_data_o.
  always_comb begin
    head       = q[rptr];
    head_valid = (count != '0);
    head_we    = head_valid && head.we && (head.rd != '0);
    in_ready_o = (count < CW'(DEPTH));
    push       = in_valid_i && in_ready_o;
    pop        = head_valid && (rf_gnt_i || !head_we);
    rf_we_o    = head_we;
    rf_addr_o  = head_valid ? head.rd : '0;
    rf_data_o  = head_valid ? head.result : '0;
    count_o    = count;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) q[wptr] <= push_entry;
  end

`ifdef WB_TRACER_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      trc_valid_o    <= 1'b0;
      trc_pc_o       <= '0;
      trc_instr_o    <= '0;
      trc_reg_addr_o <= '0;
      trc_reg_data_o <= '0;
      trc_is_load_o  <= 1'b0;
    end else begin
      trc_valid_o <= pop;
      if (pop) begin
        trc_pc_o       <= head.pc;
        trc_instr_o    <= head.instr;
        trc_reg_addr_o <= head.rd;
        trc_reg_data_o <= head.result;
        trc_is_load_o  <= head.is_load;
      end
    end
  end
`endif

endmodule

// File: tb/tb_write_back_queue.sv
// Self-checking bench for write_back_queue: directed scenarios plus random traffic
// against a queue-based reference model (trace checks when WB_TRACER_EN is defined).
module tb_write_back_queue;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic [XLEN-1:0]  ex_result_i = '0;
  logic [XLEN-1:0]  load_data_i = '0;
  logic [4:0]       rd_addr_i = '0;
  logic             rd_we_i = 1'b0;
  logic             is_load_i = 1'b0;
  logic [2:0]       ld_type_i = '0;
  logic             rf_we_o;
  logic [4:0]       rf_addr_o;
  logic [XLEN-1:0]  rf_data_o;
  logic             rf_gnt_i = 1'b0;
  logic [2:0]       count_o;
`ifdef WB_TRACER_EN
  logic [XLEN-1:0]  pc_i = '0;
  logic [31:0]      instr_i = '0;
  logic             trc_valid_o;
  logic [XLEN-1:0]  trc_pc_o;
  logic [31:0]      trc_instr_o;
  logic [4:0]       trc_reg_addr_o;
  logic [XLEN-1:0]  trc_reg_data_o;
  logic             trc_is_load_o;
`endif

  write_back_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .ex_result_i    (ex_result_i),
    .load_data_i    (load_data_i),
    .rd_addr_i      (rd_addr_i),
    .rd_we_i        (rd_we_i),
    .is_load_i      (is_load_i),
    .ld_type_i      (ld_type_i),
    .rf_we_o        (rf_we_o),
    .rf_addr_o      (rf_addr_o),
    .rf_data_o      (rf_data_o),
    .rf_gnt_i       (rf_gnt_i),
    .count_o        (count_o)
`ifdef WB_TRACER_EN
    ,
    .pc_i           (pc_i),
    .instr_i        (instr_i),
    .trc_valid_o    (trc_valid_o),
    .trc_pc_o       (trc_pc_o),
    .trc_instr_o    (trc_instr_o),
    .trc_reg_addr_o (trc_reg_addr_o),
    .trc_reg_data_o (trc_reg_data_o),
    .trc_is_load_o  (trc_is_load_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ld;
  } ref_t;

  ref_t mq[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
`ifdef WB_TRACER_EN
  bit   exp_trc_v = 1'b0;
  ref_t exp_trc;
`endif

  // Reference load result from the load-type rules, using plain integer arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] lt, input logic [1:0] off,
                                           input logic [31:0] w);
    int unsigned b;
    int unsigned h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (lt)
      3'b000:  return (b >= 128) ? (b + 32'hFFFF_FF00) : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? (h + 32'hFFFF_0000) : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit hv;
    hv = (mq.size() > 0);
    check("count", 64'(count_o), 64'(mq.size()));
    check("in_ready", 64'(in_ready_o), 64'(mq.size() < DEPTH));
    if (hv) begin
      check("rf_we", 64'(rf_we_o), 64'(mq[0].we && (mq[0].rd != 0)));
      check("rf_addr", 64'(rf_addr_o), 64'(mq[0].rd));
      check("rf_data", 64'(rf_data_o), 64'(mq[0].data));
    end else begin
      check("rf_we_empty", 64'(rf_we_o), 64'd0);
    end
`ifdef WB_TRACER_EN
    check("trc_valid", 64'(trc_valid_o), 64'(exp_trc_v));
    if (exp_trc_v) begin
      check("trc_pc", 64'(trc_pc_o), 64'(exp_trc.pc));
      check("trc_instr", 64'(trc_instr_o), 64'(exp_trc.instr));
      check("trc_addr", 64'(trc_reg_addr_o), 64'(exp_trc.rd));
      check("trc_data", 64'(trc_reg_data_o), 64'(exp_trc.data));
      check("trc_is_load", 64'(trc_is_load_o), 64'(exp_trc.ld));
    end
`endif
  endtask

  // One clock: check at the falling edge, drive, advance the model over the rising edge.
  task automatic step(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                      input logic [2:0] lt, input logic [31:0] ex, input logic [31:0] ldd,
                      input logic gnt);
    ref_t e;
    bit   do_push;
    bit   do_pop;
    check_outputs();
    in_valid_i  = v;
    rd_addr_i   = rd;
    rd_we_i     = we;
    is_load_i   = ld;
    ld_type_i   = lt;
    ex_result_i = ex;
    load_data_i = ldd;
    rf_gnt_i    = gnt;
    e.rd    = rd;
    e.we    = we;
    e.ld    = ld;
    e.data  = ld ? ref_load(lt, ex[1:0], ldd) : ex;
    e.pc    = $urandom;
    e.instr = $urandom;
`ifdef WB_TRACER_EN
    pc_i    = e.pc;
    instr_i = e.instr;
`endif
    do_push = v && (mq.size() < DEPTH);
    do_pop  = 1'b0;
    if (mq.size() > 0) do_pop = gnt || !(mq[0].we && (mq[0].rd != 0));
    @(posedge clk);
`ifdef WB_TRACER_EN
    exp_trc_v = do_pop;
    if (do_pop) exp_trc = mq[0];
`endif
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(e);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset      = 1'b1;
    in_valid_i = 1'b1;
    rf_gnt_i   = 1'b1;
    @(posedge clk);
    mq.delete();
`ifdef WB_TRACER_EN
    exp_trc_v = 1'b0;
`endif
    @(negedge clk);
    reset      = 1'b0;
    in_valid_i = 1'b0;
    rf_gnt_i   = 1'b0;
  endtask

  task automatic push_alu(input logic [4:0] rd, input logic [31:0] val, input logic gnt);
    step(1'b1, rd, 1'b1, 1'b0, 3'b010, val, 32'h0, gnt);
  endtask

  task automatic idle(input logic gnt);
    step(1'b0, 5'd0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0, gnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    apply_reset();
    check("reset_count", 64'(count_o), 64'd0);
    check("reset_ready", 64'(in_ready_o), 64'd1);
    check("reset_we", 64'(rf_we_o), 64'd0);
    check("reset_addr", 64'(rf_addr_o), 64'd0);
    check("reset_data", 64'(rf_data_o), 64'd0);
`ifdef WB_TRACER_EN
    check("reset_trc_valid", 64'(trc_valid_o), 64'd0);
    check("reset_trc_data", 64'(trc_reg_data_o), 64'd0);
`endif

    // Load alignment and extension, each result checked against fixed constants.
    step(1'b1, 5'd3, 1'b1, 1'b1, 3'b000, 32'h0000_1003, 32'h80FF_1234, 1'b0);
    check("lb_latency_count", 64'(count_o), 64'd1);
    check("lb_data", 64'(rf_data_o), 64'hFFFF_FF80);
    step(1'b1, 5'd4, 1'b1, 1'b1, 3'b100, 32'h0000_1003, 32'h80FF_1234, 1'b1);
    check("lbu_data", 64'(rf_data_o), 64'h0000_0080);
    step(1'b1, 5'd5, 1'b1, 1'b1, 3'b001, 32'h0000_2002, 32'h8001_0000, 1'b1);
    check("lh_data", 64'(rf_data_o), 64'hFFFF_8001);
    step(1'b1, 5'd6, 1'b1, 1'b1, 3'b101, 32'h0000_2002, 32'h8001_0000, 1'b1);
    check("lhu_data", 64'(rf_data_o), 64'h0000_8001);
    step(1'b1, 5'd7, 1'b1, 1'b1, 3'b111, 32'h0000_2001, 32'hCAFE_F00D, 1'b1);
    check("undef_lw_data", 64'(rf_data_o), 64'hCAFE_F00D);
    idle(1'b1);

    // Fill with no grant, offer a fifth entry, then drain in order.
    for (int i = 0; i < 4; i++) push_alu(5'(i + 1), 32'(32'hA000 + i), 1'b0);
    check("full_count", 64'(count_o), 64'd4);
    check("full_ready", 64'(in_ready_o), 64'd0);
    push_alu(5'd9, 32'hDEAD_BEEF, 1'b0);
    check("full_reject_count", 64'(count_o), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check("drain_we", 64'(rf_we_o), 64'd1);
      check("drain_addr", 64'(rf_addr_o), 64'(i + 1));
      check("drain_data", 64'(rf_data_o), 64'(32'hA000 + i));
      idle(1'b1);
    end
    check("drain_empty", 64'(count_o), 64'd0);

    // rd=0 with write enable, and write enable low: retire without grant.
    push_alu(5'd0, 32'h1111_1111, 1'b0);
    check("rd0_we", 64'(rf_we_o), 64'd0);
    check("rd0_count", 64'(count_o), 64'd1);
    idle(1'b0);
    check("rd0_retired", 64'(count_o), 64'd0);
    step(1'b1, 5'd12, 1'b0, 1'b0, 3'b010, 32'h2222_2222, 32'h0, 1'b0);
    check("nowe_we", 64'(rf_we_o), 64'd0);
    idle(1'b0);
    check("nowe_retired", 64'(count_o), 64'd0);

    // Simultaneous push/pop at two entries, then enough traffic to wrap pointers.
    push_alu(5'd20, 32'h0000_0014, 1'b0);
    push_alu(5'd21, 32'h0000_0015, 1'b0);
    push_alu(5'd22, 32'h0000_0016, 1'b1);
    check("pushpop_count", 64'(count_o), 64'd2);
    for (int i = 0; i < 9; i++) push_alu(5'(i + 1), 32'(32'hB000 + i), 1'b1);
    check("wrap_count", 64'(count_o), 64'd2);
    idle(1'b1);
    idle(1'b1);
    check("wrap_drained", 64'(count_o), 64'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 31)), 1'($urandom),
           1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom,
           ($urandom_range(0, 1) == 1));
    end
    for (int i = 0; i < 6; i++) idle(1'b1);

    // Reset with three queued entries discards them.
    for (int i = 0; i < 3; i++) push_alu(5'(i + 1), 32'(32'hC000 + i), 1'b0);
    check("prereset_count", 64'(count_o), 64'd3);
    apply_reset();
    check("midreset_count", 64'(count_o), 64'd0);
    check("midreset_we", 64'(rf_we_o), 64'd0);
    check("midreset_ready", 64'(in_ready_o), 64'd1);
`ifdef WB_TRACER_EN
    check("midreset_trc_valid", 64'(trc_valid_o), 64'd0);
`endif
    push_alu(5'd30, 32'h3030_3030, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/write_back_queue.md
WRITE_BACK_QUEUE -- requirements
Module: write_back_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, data path width.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries; power of two, >=2.
REQ-003 SHALL have port clk input 1: sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset input 1: synchronous, active-high reset.
REQ-005 SHALL have ports in_valid_i input 1 and in_ready_o output 1: producer handshake.
REQ-006 SHALL have port ex_result_i input XLEN: execute result, or load address for loads.
REQ-007 SHALL have port load_data_i input XLEN: raw aligned memory word.
REQ-008 SHALL have ports rd_addr_i input 5, rd_we_i input 1, is_load_i input 1, ld_type_i input 3: destination, write enable, load flag, funct3 load type.
REQ-009 SHALL have ports rf_we_o output 1, rf_addr_o output 5, rf_data_o output XLEN, rf_gnt_i input 1: register-file write request and grant.
REQ-010 SHALL have port count_o output $clog2(DEPTH)+1: current occupancy.
REQ-011 SHALL have ports pc_i input XLEN and instr_i input 32, plus tracer outputs trc_valid_o 1, trc_pc_o XLEN, trc_instr_o 32, trc_reg_addr_o 5, trc_reg_data_o XLEN, trc_is_load_o 1, only when WB_TRACER_EN is defined.

Function
REQ-012 SHALL push one entry when in_valid_i && in_ready_o; in_ready_o = (count < DEPTH), with no pop-through while full.
REQ-013 SHALL compute the entry result at push: if is_load_i, aligned/extended load data; else ex_result_i.
REQ-014 SHALL align loads with byte offset ex_result_i[1:0] (LB/LBU: byte lane offset; LH/LHU: halfword lane offset[1]; LW: full word), then sign-extend for LB/LH and zero-extend for LBU/LHU.
REQ-015 SHALL treat an undefined ld_type_i (011, 110, 111) as LW.
REQ-016 SHALL present the head entry on rf_* combinationally from registered queue state; an entry pushed into an empty queue appears on the cycle after push (latency 1).
REQ-017 SHALL drive rf_we_o = head valid && head.we && head.rd != 0.
REQ-018 SHALL pop the head when rf_we_o && rf_gnt_i, or when the head is valid and rf_we_o is low (no-write retire, no grant needed).
REQ-019 SHALL retire strictly in push order; push and pop in one cycle leave count unchanged.
REQ-020 SHALL wrap read/write pointers modulo DEPTH.
REQ-021 SHALL hold rf_addr_o/rf_data_o stable while rf_we_o is high and rf_gnt_i is low.

Reset
REQ-022 SHALL, on reset, clear pointers and count; in_ready_o=1, rf_we_o=0, count_o=0, rf_addr_o=0, rf_data_o=0, all trc_* outputs 0.
REQ-023 SHALL discard all queued entries when reset is asserted mid-operation; no pop or trace event on that cycle.

Configuration
REQ-024 SHALL, with WB_TRACER_EN defined, store pc/instr per entry and register trc_* one cycle after each pop, with trc_valid_o a one-cycle pulse per retired entry and trc_reg_data_o equal to the retired result.
REQ-025 SHALL, without WB_TRACER_EN, omit the pc_i, instr_i and trc_* ports and their storage; all other behaviour is identical.

Structure
REQ-026 SHALL take from shared package wb_pkg the ld_type_e enum (LB=000, LH=001, LW=010, LBU=100, LHU=101) and the wb_entry_t struct (rd, we, result, optional pc/instr/is_load).
REQ-027 SHALL implement alignment and extension in a combinational sub-module load_align.

Verification
REQ-028 SHALL cover LB, load_data_i=32'h80FF_1234, ex_result_i[1:0]=3 -> rf_data_o=32'hFFFF_FF80; LBU same -> 32'h0000_0080.
REQ-029 SHALL cover LH, offset 2, load_data_i=32'h8001_0000 -> 32'hFFFF_8001; LHU -> 32'h0000_8001.
REQ-030 SHALL cover 4 pushes with rf_gnt_i=0 -> count_o=4, in_ready_o=0; a 5th in_valid_i is not accepted; then rf_gnt_i=1 -> 4 in-order writes, one per cycle.
REQ-031 SHALL cover rd_addr_i=0 with rd_we_i=1, and rd_we_i=0 -> rf_we_o stays 0 and the entry retires without grant one cycle after push.
REQ-032 SHALL cover simultaneous push and pop at count_o=2 -> count_o stays 2; pointer wrap after 9 consecutive pushes and pops -> data order preserved.
REQ-033 SHALL cover reset asserted with count_o=3 -> next cycle count_o=0, rf_we_o=0, in_ready_o=1; with WB_TRACER_EN, trc_valid_o pulses exactly once per retired entry.
